bdi_decompressor: RTL and testbench

Parametrised, streaming base-delta-immediate (BDI) cache-line decompressor with valid/ready handshakes on both sides. It accepts one encoded line per cycle and returns the reconstructed line after one registered stage. Illegal encodings are flagged rather than silently dropped, and a per-block counter records every line delivered. It sits between the compressed-line store and the cache fill path.

---
 rtl/bdi_pkg.sv | 38 +++
 rtl/bdi_word_recon.sv | 13 +
 rtl/bdi_decompressor.sv | 146 ++++++++++++++
 tb/tb_bdi_decompressor.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bdi_pkg.sv
// Shared BDI encoding definitions: CoN codes and per-mode base/delta geometry.
// Used by both the compressor and the decompressor.
package bdi_pkg;

   localparam int unsigned CON_W = 4;

   localparam logic [CON_W-1:0] CON_ZERO  = 4'd0;
   localparam logic [CON_W-1:0] CON_B8_D1 = 4'd1;
   localparam logic [CON_W-1:0] CON_B8_D2 = 4'd2;
   localparam logic [CON_W-1:0] CON_B8_D4 = 4'd3;
   localparam logic [CON_W-1:0] CON_B4_D1 = 4'd4;
   localparam logic [CON_W-1:0] CON_B4_D2 = 4'd5;
   localparam logic [CON_W-1:0] CON_B2_D1 = 4'd6;
   localparam logic [CON_W-1:0] CON_REP   = 4'd7;
   localparam logic [CON_W-1:0] CON_RAW   = 4'd8;

   typedef struct packed {
      logic [3:0] base_bytes;
      logic [3:0] delta_bytes;
   } bd_geom_t;

   // Base/delta sizes in bytes; zero for codes that are not base-delta modes.
   function automatic bd_geom_t con_geom(input logic [CON_W-1:0] con);
      bd_geom_t g;
      g = '0;
      case (con)
         CON_B8_D1: g = '{base_bytes: 4'd8, delta_bytes: 4'd1};
         CON_B8_D2: g = '{base_bytes: 4'd8, delta_bytes: 4'd2};
         CON_B8_D4: g = '{base_bytes: 4'd8, delta_bytes: 4'd4};
         CON_B4_D1: g = '{base_bytes: 4'd4, delta_bytes: 4'd1};
         CON_B4_D2: g = '{base_bytes: 4'd4, delta_bytes: 4'd2};
         CON_B2_D1: g = '{base_bytes: 4'd2, delta_bytes: 4'd1};
         default:   g = '0;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/bdi_word_recon.sv
// Reconstructs one word as base +/- zero-extended delta, wrapping at BASE_W bits.
module bdi_word_recon #(
   parameter int unsigned BASE_W = 64
) (
   input  logic [BASE_W-1:0] base_i,
   input  logic [BASE_W-1:0] delta_i,
   input  logic              flag_i,
   output logic [BASE_W-1:0] word_o
);

   assign word_o = flag_i ? (base_i + delta_i) : (base_i - delta_i);

endmodule

// File: rtl/bdi_decompressor.sv
// Streaming BDI cache-line decompressor: one encoded line per cycle in,
// reconstructed line out through a single valid/ready pipeline register.
module bdi_decompressor
   import bdi_pkg::*;
#(
   parameter int unsigned LINE_W = 256,
   parameter int unsigned ENC_W  = LINE_W + 4,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ENC_W-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LINE_W-1:0] out_line,
   output logic [CON_W-1:0]  out_con,
   output logic              out_err,
   output logic [CNT_W-1:0]  lines_out
);

   localparam int unsigned NUM_BD = 6;
   localparam int unsigned REP_N  = LINE_W / 64;

   logic [LINE_W-1:0] body;
   logic [CON_W-1:0]  con;
   logic [LINE_W-1:0] bd_line [NUM_BD];

   assign body = in_data[ENC_W-1:CON_W];
   assign con  = in_data[CON_W-1:0];

   // One reconstruction array per base-delta mode; the CoN mux picks the result.
   for (genvar m = 0; m < NUM_BD; m++) begin : g_mode
      localparam bd_geom_t    GEOM = con_geom(CON_W'(m + 1));
      localparam int unsigned BW   = 8 * 32'(GEOM.base_bytes);
      localparam int unsigned DW   = 8 * 32'(GEOM.delta_bytes);
      localparam int unsigned NW   = LINE_W / BW;
      localparam int unsigned P0   = NW - 1;

      logic [LINE_W-1:0] words;
      logic [BW-1:0]     base;

      assign base           = body[P0 +: BW];
      assign words[BW-1:0]  = base;

      for (genvar k = 1; k < NW; k++) begin : g_word
         localparam int unsigned OFF = P0 + BW + DW * k;
         logic [BW-1:0] delta;

         // Slots running past the body edge read as zero.
         if (OFF + DW <= LINE_W) begin : g_full
            assign delta = BW'(body[OFF +: DW]);
         end else if (OFF < LINE_W) begin : g_part
            assign delta = BW'(body[LINE_W-1:OFF]);
         end else begin : g_none
            assign delta = '0;
         end

         bdi_word_recon #(
            .BASE_W (BW)
         ) u_recon (
            .base_i  (base),
            .delta_i (delta),
            .flag_i  (body[k-1]),
            .word_o  (words[k*BW +: BW])
         );
      end

      assign bd_line[m] = words;
   end

   logic [LINE_W-1:0] dec_line;
   logic              dec_err;

   always_comb begin
      dec_line = '0;
      dec_err  = 1'b0;
      case (con)
         CON_ZERO:  dec_line = '0;
         CON_B8_D1: dec_line = bd_line[0];
         CON_B8_D2: dec_line = bd_line[1];
         CON_B8_D4: dec_line = bd_line[2];
         CON_B4_D1: dec_line = bd_line[3];
         CON_B4_D2: dec_line = bd_line[4];
         CON_B2_D1: dec_line = bd_line[5];
         CON_REP:   dec_line = {REP_N{body[63:0]}};
         CON_RAW:   dec_line = body;
         default:   dec_err  = 1'b1;
      endcase
   end

   logic              valid_q, valid_d;
   logic [LINE_W-1:0] line_q,  line_d;
   logic [CON_W-1:0]  con_q,   con_d;
   logic              err_q,   err_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic              accept;
   logic              deliver;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign deliver  = valid_q && out_ready;

   always_comb begin
      valid_d = valid_q;
      line_d  = line_q;
      con_d   = con_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      if (accept) begin
         valid_d = 1'b1;
         line_d  = dec_line;
         con_d   = con;
         err_d   = dec_err;
      end else if (deliver) begin
         valid_d = 1'b0;
      end
      if (deliver) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         line_q  <= '0;
         con_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         line_q  <= line_d;
         con_q   <= con_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid = valid_q;
   assign out_line  = line_q;
   assign out_con   = con_q;
   assign out_err   = err_q;
   assign lines_out = cnt_q;

endmodule

// File: tb/tb_bdi_decompressor.sv
// Randomized and directed bench for bdi_decompressor against an arithmetic BDI model.
module tb_bdi_decompressor;

   localparam int unsigned LINE_W = 256;
   localparam int unsigned ENC_W  = LINE_W + 4;
   localparam int unsigned CNT_W  = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [ENC_W-1:0]  in_data;
   logic              out_valid;
   logic              out_ready;
   logic [LINE_W-1:0] out_line;
   logic [3:0]        out_con;
   logic              out_err;
   logic [CNT_W-1:0]  lines_out;

   bdi_decompressor #(
      .LINE_W (LINE_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_line  (out_line),
      .out_con   (out_con),
      .out_err   (out_err),
      .lines_out (lines_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_deliv  = 0;

   typedef struct {
      logic [LINE_W-1:0] line;
      logic [3:0]        con;
      logic              err;
   } exp_t;

   exp_t exp_q[$];

   task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                           input logic [LINE_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: words built with plain integer arithmetic from the BDI rules.
   function automatic logic [LINE_W-1:0] ref_line(input logic [3:0] c,
                                                   input logic [LINE_W-1:0] b);
      int unsigned bb, db, n;
      logic [63:0] base, dl, w, mask, dmask;
      logic [LINE_W-1:0] r;
      case (c)
         4'd1: begin bb = 8; db = 1; end
         4'd2: begin bb = 8; db = 2; end
         4'd3: begin bb = 8; db = 4; end
         4'd4: begin bb = 4; db = 1; end
         4'd5: begin bb = 4; db = 2; end
         4'd6: begin bb = 2; db = 1; end
         4'd7: return {4{b[63:0]}};
         4'd8: return b;
         default: return '0;
      endcase
      n     = LINE_W / (8 * bb);
      mask  = (bb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * bb)) - 64'd1);
      dmask = (64'd1 << (8 * db)) - 64'd1;
      base  = 64'(b >> (n - 1)) & mask;
      r     = LINE_W'(base);
      for (int k = 1; k < int'(n); k++) begin
         dl = 64'(b >> (n - 1 + 8 * bb + 8 * db * k)) & dmask;
         w  = b[k-1] ? (base + dl) : (base - dl);
         w  = w & mask;
         r  = r | (LINE_W'(w) << (8 * bb * k));
      end
      return r;
   endfunction

   function automatic logic [LINE_W-1:0] rand_body();
      logic [LINE_W-1:0] v;
      for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Scoreboard: push on accept, pop and compare on every output handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (out_valid && out_ready) begin
            n_deliv++;
            if (exp_q.size() == 0) begin
               check_eq("sb_unexpected_output", LINE_W'(1), LINE_W'(0));
            end else begin
               e = exp_q.pop_front();
               check_eq("sb_line", out_line, e.line);
               check_eq("sb_con", LINE_W'(out_con), LINE_W'(e.con));
               check_eq("sb_err", LINE_W'(out_err), LINE_W'(e.err));
            end
         end
         if (in_valid && in_ready) begin
            e.con  = in_data[3:0];
            e.line = ref_line(in_data[3:0], in_data[ENC_W-1:4]);
            e.err  = (in_data[3:0] > 4'd8);
            exp_q.push_back(e);
         end
      end
   end

   task automatic send(input logic [3:0] c, input logic [LINE_W-1:0] b);
      bit got;
      got      = 1'b0;
      in_valid = 1'b1;
      in_data  = {b, c};
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (in_ready) got = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!got) check_eq("send_timeout", LINE_W'(0), LINE_W'(1));
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [LINE_W-1:0] line,
                             input logic [3:0] c, input logic e);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (out_valid) got = 1'b1;
      end
      if (!got) begin
         check_eq({tag, "_timeout"}, LINE_W'(0), LINE_W'(1));
      end else begin
         check_eq({tag, "_line"}, out_line, line);
         check_eq({tag, "_con"}, LINE_W'(out_con), LINE_W'(c));
         check_eq({tag, "_err"}, LINE_W'(out_err), LINE_W'(e));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      exp_q.delete();
      n_deliv = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [LINE_W-1:0] b, ba, bb_, la, lb;
      logic [3:0]        ca, cb;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out_valid", LINE_W'(out_valid), LINE_W'(0));
      check_eq("rst_out_line", out_line, LINE_W'(0));
      check_eq("rst_lines_out", LINE_W'(lines_out), LINE_W'(0));
      rst = 1'b0;
      #1;
      check_eq("rst_in_ready", LINE_W'(in_ready), LINE_W'(1));

      // B8/D1 directed line
      b = '0;
      b[2:0]    = 3'b101;
      b[3 +: 64] = 64'h1000;
      b[75 +: 8] = 8'h10;
      b[83 +: 8] = 8'h20;
      b[91 +: 8] = 8'h05;
      send(4'd1, b);
      expect_out("b8d1", {64'h1005, 64'h0FE0, 64'h1010, 64'h1000}, 4'd1, 1'b0);
      check_eq("b8d1_lines_out", LINE_W'(lines_out), LINE_W'(1));

      // B2/D1 wrap
      b = '0;
      b[14:0]     = 15'h7FFF;
      b[15 +: 16] = 16'hFFFF;
      b[39 +: 8]  = 8'h01;
      send(4'd6, b);
      expect_out("b2d1", {{14{16'hFFFF}}, 16'h0000, 16'hFFFF}, 4'd6, 1'b0);

      // Repeat, raw, illegal
      b = rand_body();
      b[63:0] = 64'hDEADBEEF_01234567;
      send(4'd7, b);
      expect_out("rep", {4{64'hDEADBEEF_01234567}}, 4'd7, 1'b0);
      b = {32{8'hA5}};
      send(4'd8, b);
      expect_out("raw", {32{8'hA5}}, 4'd8, 1'b0);
      send(4'hC, rand_body());
      expect_out("illegal", LINE_W'(0), 4'hC, 1'b1);
      check_eq("illegal_lines_out", LINE_W'(lines_out), LINE_W'(5));

      // Back-pressure with two lines
      apply_reset();
      out_ready = 1'b0;
      ca = 4'($urandom_range(1, 6));
      cb = 4'($urandom_range(0, 8));
      ba = rand_body();
      bb_ = rand_body();
      la = ref_line(ca, ba);
      lb = ref_line(cb, bb_);
      send(ca, ba);
      in_valid = 1'b1;
      in_data  = {bb_, cb};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("bp_hold_valid", LINE_W'(out_valid), LINE_W'(1));
         check_eq("bp_hold_line", out_line, la);
         check_eq("bp_hold_con", LINE_W'(out_con), LINE_W'(ca));
         check_eq("bp_in_ready_low", LINE_W'(in_ready), LINE_W'(0));
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_release_ready", LINE_W'(in_ready), LINE_W'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("bp_b_valid", LINE_W'(out_valid), LINE_W'(1));
      check_eq("bp_b_line", out_line, lb);
      @(posedge clk);
      #1;
      check_eq("bp_drained", LINE_W'(out_valid), LINE_W'(0));
      check_eq("bp_lines_out", LINE_W'(lines_out), LINE_W'(2));

      // Full-throughput random stream
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_data  = {rand_body(), 4'($urandom_range(0, 8))};
         @(negedge clk);
         check_eq("tp_in_ready", LINE_W'(in_ready), LINE_W'(1));
         if (i > 0) check_eq("tp_no_bubble", LINE_W'(out_valid), LINE_W'(1));
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("tp_last_valid", LINE_W'(out_valid), LINE_W'(1));
      @(posedge clk);
      #1;
      check_eq("tp_lines_out", LINE_W'(lines_out), LINE_W'(20));
      check_eq("tp_delivered", LINE_W'(n_deliv), LINE_W'(20));
      check_eq("tp_queue_empty", LINE_W'(exp_q.size()), LINE_W'(0));

      // Reset mid-stream
      out_ready = 1'b0;
      send(4'd8, rand_body());
      check_eq("mid_valid_before", LINE_W'(out_valid), LINE_W'(1));
      #2;
      rst = 1'b1;
      #1;
      check_eq("mid_rst_valid", LINE_W'(out_valid), LINE_W'(0));
      check_eq("mid_rst_line", out_line, LINE_W'(0));
      check_eq("mid_rst_con", LINE_W'(out_con), LINE_W'(0));
      check_eq("mid_rst_err", LINE_W'(out_err), LINE_W'(0));
      check_eq("mid_rst_lines_out", LINE_W'(lines_out), LINE_W'(0));
      exp_q.delete();
      n_deliv = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_eq("mid_in_ready", LINE_W'(in_ready), LINE_W'(1));
      out_ready = 1'b1;
      ca = 4'($urandom_range(1, 6));
      ba = rand_body();
      send(ca, ba);
      expect_out("mid_after", ref_line(ca, ba), ca, 1'b0);
      check_eq("mid_lines_out", LINE_W'(lines_out), LINE_W'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
